// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and the core it feeds.
package cpu_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_if.sv
// Control, load and instruction-delivery signals between the core side and the fetch stage.
interface inst_fetch_if #(
  parameter int DEPTH = 64
);
  import cpu_pkg::*;
  localparam int AW = $clog2(DEPTH);

  logic              load_en;
  logic [INST_W-1:0] load_data;
  logic              run;
  logic              stall;
  logic              branch_en;
  logic [31:0]       branch_target;
  logic [INST_W-1:0] Inst;
  logic [31:0]       pc;
  logic              valid;
  logic [AW:0]       prog_len;
  logic              halted;
  logic              overflow;

  modport master (
    output load_en, load_data, run, stall, branch_en, branch_target,
    input  Inst, pc, valid, prog_len, halted, overflow
  );

  modport slave (
    input  load_en, load_data, run, stall, branch_en, branch_target,
    output Inst, pc, valid, prog_len, halted, overflow
  );
endinterface

// File: rtl/inst_mem.sv
// Instruction store: one synchronous write port, one synchronous read port with read enable.
module inst_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [INST_W-1:0] rdata_o
);
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM; stale contents are masked by valid upstream.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: program loader, PC/FSM control and one instruction per cycle into the core.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [AW:0]       prog_len_q, prog_len_d;
  logic              overflow_q, overflow_d;
  logic              mem_we, mem_re;
  logic [INST_W-1:0] mem_rdata;
  logic              past_end;
  logic              mem_full;
  logic              unused_target_bits;

  assign past_end = fetch_pc_q[31:2] >= 30'(prog_len_q);
  assign mem_full = prog_len_q == (AW+1)'(DEPTH);
  assign unused_target_bits = ^bus.branch_target[1:0];

  // NOTE: combinational next-state uses blocking '=' with a default for every signal, so no latches form.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    prog_len_d = prog_len_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_en) begin
          if (mem_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + (AW+1)'(1);
          end
        end else if (bus.run) begin
          fetch_pc_d = '0;
          state_d    = (prog_len_q != '0) ? RUN : HALT;
        end
      end
      RUN: begin
        if (bus.branch_en) begin
          fetch_pc_d = {bus.branch_target[31:2], 2'b00};
          valid_d    = 1'b0;
        end else if (!bus.stall) begin
          if (past_end) begin
            state_d = HALT;
            valid_d = 1'b0;
          end else begin
            mem_re     = 1'b1;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      HALT: valid_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      prog_len_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      prog_len_q <= prog_len_d;
      overflow_q <= overflow_d;
    end
  end

  // The memory read register doubles as the Inst register; valid_q masks it to NOP.
  inst_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(prog_len_q[AW-1:0]),
    .wdata_i(bus.load_data),
    .re_i   (mem_re),
    .raddr_i(fetch_pc_q[AW+1:2]),
    .rdata_o(mem_rdata)
  );

  assign bus.Inst     = valid_q ? mem_rdata : NOP_INST;
  assign bus.pc       = pc_q;
  assign bus.valid    = valid_q;
  assign bus.prog_len = prog_len_q;
  assign bus.halted   = (state_q == HALT);
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected words queued by stimulus, checked by a negedge monitor.
module tb_inst_fetch;
  import cpu_pkg::*;
  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];

  inst_fetch_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_inst", bus.Inst, NOP_INST);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_prog_len", 32'(bus.prog_len), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
  endtask

  task automatic load_word(input logic [31:0] w);
    bus.load_en   = 1'b1;
    bus.load_data = w;
    tick();
    bus.load_en = 1'b0;
  endtask

  // Pulse run; returns once word 0 is on Inst (two edges later).
  task automatic start_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: every valid word must match the head of the queue; invalid cycles must show NOP.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got inst %h pc %h, required no valid word", bus.Inst, bus.pc);
        end else begin
          e = exp_q.pop_front();
          check("mon_inst", bus.Inst, e.inst);
          check("mon_pc", bus.pc, e.pc);
        end
      end else begin
        check("mon_nop_when_invalid", bus.Inst, NOP_INST);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [4];
    n_cmp  = 0;
    n_fail = 0;
    w[0] = 32'h20010001;
    w[1] = 32'h20020001;
    w[2] = 32'h20030003;
    w[3] = 32'h20040004;
    rst = 1'b1;
    bus.load_en = 1'b0;
    bus.load_data = '0;
    bus.run = 1'b0;
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_target = '0;

    // Reset and two-word program
    do_reset();
    check_reset_values();
    load_word(w[0]);
    load_word(w[1]);
    check("t1_prog_len", 32'(bus.prog_len), 32'd2);
    expect_word(w[0], 32'h0);
    expect_word(w[1], 32'h4);
    start_run();
    tick();
    tick();
    check("t1_valid_after_end", 32'(bus.valid), 32'h0);
    check("t1_halted", 32'(bus.halted), 32'h1);
    check_drained("t1_drained");

    // Stall holds word 0 for three extra cycles
    do_reset();
    for (int i = 0; i < 3; i++) load_word(w[i]);
    repeat (4) expect_word(w[0], 32'h0);
    expect_word(w[1], 32'h4);
    expect_word(w[2], 32'h8);
    start_run();
    bus.stall = 1'b1;
    repeat (3) tick();
    check("t2_pc_frozen", bus.pc, 32'h0);
    bus.stall = 1'b0;
    repeat (3) tick();
    check("t2_halted", 32'(bus.halted), 32'h1);
    check_drained("t2_drained");

    // Branch to 0xE (word 3) while word 1 is on Inst; run with load is ignored
    do_reset();
    for (int i = 0; i < 3; i++) load_word(w[i]);
    bus.run = 1'b1;
    load_word(w[3]);
    bus.run = 1'b0;
    tick();
    check("t3_load_beats_run", 32'(bus.halted), 32'h0);
    check("t3_prog_len", 32'(bus.prog_len), 32'd4);
    expect_word(w[0], 32'h0);
    expect_word(w[1], 32'h4);
    expect_word(w[3], 32'hC);
    start_run();
    tick();
    bus.branch_en = 1'b1;
    bus.branch_target = 32'h0000000E;
    tick();
    bus.branch_en = 1'b0;
    check("t3_bubble_valid", 32'(bus.valid), 32'h0);
    check("t3_bubble_inst", bus.Inst, NOP_INST);
    tick();
    check("t3_target_pc", bus.pc, 32'hC);
    tick();
    check("t3_halted", 32'(bus.halted), 32'h1);
    check_drained("t3_drained");

    // Branch beats stall: to word 1, then out of range
    do_reset();
    for (int i = 0; i < 4; i++) load_word(w[i]);
    expect_word(w[0], 32'h0);
    expect_word(w[1], 32'h4);
    start_run();
    bus.stall = 1'b1;
    bus.branch_en = 1'b1;
    bus.branch_target = 32'h4;
    tick();
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    check("t4_bubble_valid", 32'(bus.valid), 32'h0);
    tick();
    bus.stall = 1'b1;
    bus.branch_en = 1'b1;
    bus.branch_target = 32'h100;
    tick();
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    check("t4_far_bubble_halted", 32'(bus.halted), 32'h0);
    tick();
    check("t4_far_halted", 32'(bus.halted), 32'h1);
    check("t4_far_valid", 32'(bus.valid), 32'h0);
    check_drained("t4_drained");

    // Overflow: DEPTH+1 loads, word 0 intact, then empty-program run
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word(32'hA000_0000 | 32'(i));
    load_word(32'hDEADBEEF);
    check("t5_prog_len", 32'(bus.prog_len), 32'(DEPTH));
    check("t5_overflow", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) expect_word(32'hA000_0000 | 32'(i), 32'(i * 4));
    start_run();
    repeat (DEPTH) tick();
    check("t5_halted", 32'(bus.halted), 32'h1);
    check_drained("t5_drained");
    do_reset();
    check_reset_values();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    check("t5_empty_halted", 32'(bus.halted), 32'h1);
    repeat (3) tick();
    check("t5_empty_valid", 32'(bus.valid), 32'h0);

    // Load during RUN ignored, then reset mid-run and restart
    do_reset();
    for (int i = 0; i < 3; i++) load_word(w[i]);
    expect_word(w[0], 32'h0);
    expect_word(w[1], 32'h4);
    start_run();
    load_word(32'h12345678);
    check("t6_prog_len_unchanged", 32'(bus.prog_len), 32'd3);
    check("t6_overflow_unchanged", 32'(bus.overflow), 32'h0);
    rst = 1'b1;
    tick();
    check_reset_values();
    rst = 1'b0;
    exp_q.delete();
    load_word(w[2]);
    expect_word(w[2], 32'h0);
    start_run();
    tick();
    check("t6_restart_halted", 32'(bus.halted), 32'h1);
    check_drained("t6_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
